// File: rtl/y_alu.sv
// Execute-stage ALU: AND/OR/ADD/SUB/unsigned SLT with a combinational zero flag,
// plus a one-cycle registered copy of result, zero flag and signed overflow.
module y_alu #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] z,
  output logic             ex,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] z_q,
  output logic             ex_q,
  output logic             ovf_q
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // SUB and SLT both run the shared adder as a + ~b + 1; carry-out is the "no borrow" bit.
  assign sub = (op == OP_SUB) || (op == OP_SLT);
  assign bx  = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    z = '0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD,
      OP_SUB:  z = sum[WIDTH-1:0];
      OP_SLT:  z = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
      default: z = '0;
    endcase
  end

  assign ex  = (z == '0);
  assign ovf = ((op == OP_ADD) || (op == OP_SUB)) &&
               (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q   <= '0;
      ex_q  <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      z_q   <= z;
      ex_q  <= ex;
      ovf_q <= ovf;
    end
  end

endmodule

// File: tb/tb_y_alu.sv
// Self-checking bench for y_alu: random vectors against an arithmetic reference
// model, then directed corner cases and synchronous-reset behaviour.
module tb_y_alu;

  logic [31:0] z, a, b, z_q;
  logic        ex, ex_q, ovf_q;
  logic [2:0]  op;
  logic        clk, rst_n;

  int errors = 0;
  int checks = 0;

  y_alu #(.WIDTH(32)) dut (
    .z(z), .ex(ex), .a(a), .b(b), .op(op),
    .clk(clk), .rst_n(rst_n),
    .z_q(z_q), .ex_q(ex_q), .ovf_q(ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_z(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Overflow as "true signed result does not fit in 32 bits".
  function automatic logic ref_ovf(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint r;
    if (o == 3'b010)      r = longint'($signed(x)) + longint'($signed(y));
    else if (o == 3'b110) r = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb_chk(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] e;
    op = o; a = x; b = y;
    #1;
    e = ref_z(o, x, y);
    chk({tag, ".z"}, z, e);
    chk({tag, ".ex"}, {31'd0, ex}, {31'd0, e == 32'd0});
  endtask

  task automatic reg_chk(input string tag, input logic [31:0] ez, input logic eex, input logic eovf);
    chk({tag, ".z_q"}, z_q, ez);
    chk({tag, ".ex_q"}, {31'd0, ex_q}, {31'd0, eex});
    chk({tag, ".ovf_q"}, {31'd0, ovf_q}, {31'd0, eovf});
  endtask

  initial begin
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    logic [2:0] o;
    logic [31:0] x, y, e;
    int err0;

    rst_n = 1'b0; op = 3'b010; a = 32'd5; b = 32'd7;
    @(posedge clk); @(posedge clk); #1;
    reg_chk("reset", 32'd0, 1'b1, 1'b0);
    chk("reset.live_z", z, 32'd12);
    rst_n = 1'b1;

    // Random vectors; stop the loop at the first mismatch.
    err0 = errors;
    for (int i = 0; i < 300; i++) begin
      o = ops[$urandom_range(0, 4)];
      x = $urandom;
      y = ($urandom_range(0, 1) == 1) ? x : 32'($urandom);
      comb_chk("rand", o, x, y);
      @(posedge clk); #1;
      e = ref_z(o, x, y);
      reg_chk("rand", e, e == 32'd0, ref_ovf(o, x, y));
      if (errors != err0) break;
    end

    comb_chk("slt_unsigned", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
    chk("slt_unsigned.lit", z, 32'd1);
    comb_chk("slt_swapped", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("slt_swapped.lit", {31'd0, ex}, 32'd1);
    comb_chk("slt_equal", 3'b111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    comb_chk("sub_equal", 3'b110, 32'h1234_5678, 32'h1234_5678);
    chk("sub_equal.lit", {31'd0, ex}, 32'd1);
    comb_chk("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1);
    @(posedge clk); #1;
    reg_chk("add_wrap", 32'd0, 1'b1, 1'b0);

    comb_chk("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf.lit", z, 32'h8000_0000);
    @(posedge clk); #1;
    reg_chk("add_ovf", 32'h8000_0000, 1'b0, 1'b1);

    comb_chk("sub_ovf", 3'b110, 32'h8000_0000, 32'd1);
    @(posedge clk); #1;
    reg_chk("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);

    for (int k = 3; k <= 5; k++) begin
      comb_chk($sformatf("undef%0d", k), 3'(k), 32'($urandom) | 32'h1, 32'($urandom) | 32'h1);
      chk($sformatf("undef%0d.lit", k), {31'd0, ex}, 32'd1);
    end

    // Reset is sampled only at the clock edge.
    comb_chk("pre_rst", 3'b001, 32'h00F0_0000, 32'h0000_000F);
    @(posedge clk); #1;
    reg_chk("pre_rst", 32'h00F0_000F, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    reg_chk("rst_midcycle", 32'h00F0_000F, 1'b0, 1'b0);
    @(posedge clk); #1;
    reg_chk("rst_edge", 32'd0, 1'b1, 1'b0);
    chk("rst_edge.live_z", z, 32'h00F0_000F);
    chk("rst_edge.live_ex", {31'd0, ex}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    reg_chk("rst_release", 32'h00F0_000F, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y_alu.md
Name: y_alu

Overview:
- 32-bit combinational ALU with a zero flag, for the datapath execute stage.
- It computes AND, OR, ADD, SUB and unsigned set-less-than, selected by a 3-bit opcode.
- Primary result and zero flag are combinational (zero latency).
- A clocked stage registers the result, zero flag and a signed-overflow flag for pipeline use.

Parameters:
- WIDTH, 32, operand/result width in bits (bench runs only 32).

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst_n  input  1  synchronous active-low reset
- z  output  WIDTH  combinational result
- ex  output  1  combinational zero flag, 1 when z == 0
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- z_q  output  WIDTH  z registered on clk
- ex_q  output  1  ex registered on clk
- ovf_q  output  1  registered signed overflow of ADD/SUB

Behaviour:
- Positional order of the first five ports is fixed: z, ex, a, b, op. Instances connect by position.
- Opcode map:
  - 000: z = a & b
  - 001: z = a | b
  - 010: z = a + b, modulo 2^WIDTH, carry discarded
  - 110: z = a - b, modulo 2^WIDTH (a + ~b + 1)
  - 111: z = 1 if a < b as UNSIGNED values, else 0. Upper WIDTH-1 bits are always 0.
  - 011, 100, 101: z = 0.
- ADD and SUB share one adder. B is inverted and carry-in is set for op 110.
- SLT uses the unsigned borrow of a - b: z[0] = NOT carry-out of a + ~b + 1.
- ex = 1 exactly when z == 0, for every opcode, including the undefined opcodes (ex = 1 there).
- z and ex are purely combinational: no latches, and valid within one delta/settle time of an input change. No clock is needed for them.
- Overflow (combinational, internal): for ADD/SUB, 1 when both adder inputs (a and b, or a and ~b) have equal sign bits and the result sign differs; 0 for all other ops.
- Registered stage, at each rising clk:
  - if rst_n == 0: z_q <= 0, ex_q <= 1, ovf_q <= 0.
  - else: z_q <= z, ex_q <= ex, ovf_q <= overflow.
- Latency of the registered outputs is 1 cycle.
- Reset is synchronous only. Asserting rst_n low between edges does not change z_q/ex_q/ovf_q until the next rising edge.
- z/ex are never affected by reset.
- a == b cases: SUB gives z = 0, ex = 1; SLT gives 0, ex = 1.
- Wrap-around: 0xFFFFFFFF + 1 gives z = 0, ex = 1, ovf = 0. 0x7FFFFFFF + 1 gives 0x80000000, ovf = 1.

Test Plan:
- Random a/b with b forced to a on ~50% of vectors, all five defined ops. Wait 1 time unit, then require z == reference (a&b, a|b, a+b, a-b, unsigned a<b) and ex == (reference == 0). Stop on first mismatch.
- op=111, a=0x00000001, b=0xFFFFFFFF -> z=1, ex=0. Swap operands -> z=0, ex=1. This confirms an unsigned compare.
- op=110, a=b=0x12345678 -> z=0, ex=1. op=010, a=0xFFFFFFFF, b=1 -> z=0, ex=1.
- op=010, a=0x7FFFFFFF, b=1 -> z=0x80000000. After one clk, z_q=0x80000000, ex_q=0, ovf_q=1.
- op=011/100/101 with any a, b -> z=0, ex=1.
- Hold rst_n=0 across a rising edge with nonzero result -> z_q=0, ex_q=1, ovf_q=0 while z still shows the live result. Release rst_n -> registered outputs follow z/ex one cycle later.
